alu_seq_loader: RTL and testbench

- Parametrised, sequential successor to the combinational 8-bit ALU.
- A single shared data bus is loaded in three steps, strobed by one load pulse: operand A, then operand B, then opcode.
- After the opcode load, the block executes one MIPS-funct-coded operation and registers the result with status flags.
- Sits between debounced board switches/buttons and the display/LED logic.

---
 rtl/alu_seq_loader.sv | 171 +++++++++++++++++
 tb/tb_alu_seq_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_loader.sv
// Sequential ALU: operand A, operand B and a MIPS funct opcode are loaded over one shared bus, then executed.
// Optional macro ALU_SIGNED_OVF_EN adds a registered signed-overflow flag for ADD/SUB.
module alu_seq_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  carry,
    output logic                  zero,
    output logic                  error,
    output logic                  overflow,
    output logic                  done,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6'b100110);
    localparam logic [OP_WIDTH-1:0] OP_NOR = OP_WIDTH'(6'b100111);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(6'b000011);
    localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(6'b000010);
    localparam logic [DATA_WIDTH-1:0] LP_W = DATA_WIDTH'(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_num1;
    logic [DATA_WIDTH-1:0] r_num2;
    logic [OP_WIDTH-1:0]   r_opcode;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_carry;
    logic                  r_zero;
    logic                  r_error;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_carry;
    logic                  w_err;
    logic [DATA_WIDTH:0]   w_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next;
        end
    end

    // clear wins over load; execution always completes once the opcode is in
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_A:    if (clear) w_next = S_A;  else if (load) w_next = S_B;
            S_B:    if (clear) w_next = S_A;  else if (load) w_next = S_OP;
            S_OP:   if (clear) w_next = S_A;  else if (load) w_next = S_EXEC;
            S_EXEC: w_next = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num1   <= '0;
            r_num2   <= '0;
            r_opcode <= '0;
        end else if (load && !clear) begin
            case (r_state)
                S_A:     r_num1   <= data_in;
                S_B:     r_num2   <= data_in;
                S_OP:    r_opcode <= data_in[OP_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    assign w_sum = {1'b0, r_num1} + {1'b0, r_num2};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (r_opcode)
            OP_ADD: begin
                w_res   = w_sum[DATA_WIDTH-1:0];
                w_carry = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_res   = r_num1 - r_num2;
                w_carry = (r_num1 < r_num2);
            end
            OP_AND: w_res = r_num1 & r_num2;
            OP_OR:  w_res = r_num1 | r_num2;
            OP_XOR: w_res = r_num1 ^ r_num2;
            OP_NOR: w_res = ~(r_num1 | r_num2);
            OP_SRA: begin
                if (r_num2 >= LP_W) w_res = {DATA_WIDTH{r_num1[DATA_WIDTH-1]}};
                else                w_res = DATA_WIDTH'($signed(r_num1) >>> r_num2);
            end
            OP_SRL: begin
                if (r_num2 >= LP_W) w_res = '0;
                else                w_res = r_num1 >> r_num2;
            end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_error <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_EXEC);
            if (r_state == S_EXEC) begin
                r_out   <= w_res;
                r_carry <= w_carry;
                r_zero  <= (w_res == '0);
                r_error <= w_err;
            end
        end
    end

`ifdef ALU_SIGNED_OVF_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (r_opcode == OP_ADD) begin
            w_ovf = (r_num1[DATA_WIDTH-1] == r_num2[DATA_WIDTH-1]) &&
                    (w_res[DATA_WIDTH-1] != r_num1[DATA_WIDTH-1]);
        end else if (r_opcode == OP_SUB) begin
            w_ovf = (r_num1[DATA_WIDTH-1] != r_num2[DATA_WIDTH-1]) &&
                    (w_res[DATA_WIDTH-1] != r_num1[DATA_WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    assign out   = r_out;
    assign carry = r_carry;
    assign zero  = r_zero;
    assign error = r_error;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_alu_seq_loader.sv
// Self-checking bench for alu_seq_loader (8-bit): arithmetic reference model plus directed literal checks.
module tb_alu_seq_loader;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       load;
    logic       clear;
    logic [7:0] out;
    logic       carry;
    logic       zero;
    logic       error;
    logic       overflow;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    int mPhase = 0;
    int mA = 0;
    int mB = 0;
    int mOp = 0;
    int eOut = 0;
    int eCarry = 0;
    int eZero = 1;
    int eErr = 0;
    int eOvf = 0;
    int eDone = 0;

`ifdef ALU_SIGNED_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    alu_seq_loader #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .clear    (clear),
        .out      (out),
        .carry    (carry),
        .zero     (zero),
        .error    (error),
        .overflow (overflow),
        .done     (done),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic on plain integers, including the signed interpretation for overflow
    function automatic void computeExpected(input int a, input int b, input int op,
                                            output int res, output int cy, output int er, output int ov);
        int sa;
        int sb;
        int s;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = 0; cy = 0; er = 0; ov = 0;
        case (op)
            32: begin
                s = a + b; res = s % 256; cy = (s > 255) ? 1 : 0;
                ov = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0;
            end
            34: begin
                res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0;
                ov = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0;
            end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = 255 - (a | b);
            3: begin
                if (b >= 8) res = (a >= 128) ? 255 : 0;
                else        res = (a >> b) | ((a >= 128) ? ((255 << (8 - b)) & 255) : 0);
            end
            2:  res = (b >= 8) ? 0 : (a >> b);
            default: er = 1;
        endcase
        if (!OVF_ON) ov = 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPhase = 0; mA = 0; mB = 0; mOp = 0;
            eOut = 0; eCarry = 0; eZero = 1; eErr = 0; eOvf = 0; eDone = 0;
        end else begin
            eDone = 0;
            if (mPhase == 3) begin
                computeExpected(mA, mB, mOp, eOut, eCarry, eErr, eOvf);
                eZero = (eOut == 0) ? 1 : 0;
                eDone = 1;
                mPhase = 0;
            end else if (clear) begin
                mPhase = 0;
            end else if (load) begin
                case (mPhase)
                    0: mA = int'(data_in);
                    1: mB = int'(data_in);
                    default: mOp = int'(data_in[5:0]);
                endcase
                mPhase++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            checkOutput("model_state", 32'(state), 32'(mPhase));
            checkOutput("model_out", 32'(out), 32'(eOut));
            checkOutput("model_carry", 32'(carry), 32'(eCarry));
            checkOutput("model_zero", 32'(zero), 32'(eZero));
            checkOutput("model_error", 32'(error), 32'(eErr));
            checkOutput("model_overflow", 32'(overflow), 32'(eOvf));
            checkOutput("model_done", 32'(done), 32'(eDone));
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic ld, input logic clr);
        @(negedge clk);
        data_in = d;
        load    = ld;
        clear   = clr;
        @(negedge clk);
        load  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] expOut, input logic expCarry, input logic expZero, input logic expErr);
        applyStimulus(a, 1'b1, 1'b0);
        applyStimulus(b, 1'b1, 1'b0);
        applyStimulus(op, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({name, "_out"}, 32'(out), 32'(expOut));
        checkOutput({name, "_carry"}, 32'(carry), 32'(expCarry));
        checkOutput({name, "_zero"}, 32'(zero), 32'(expZero));
        checkOutput({name, "_error"}, 32'(error), 32'(expErr));
        checkOutput({name, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        data_in = 8'h00;
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_out", 32'(out), 32'd0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        checkOutput("rst_carry", 32'(carry), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        #20 reset = 1'b0;

        runOp("and", 8'h01, 8'h02, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("and_done_single", 32'(done), 32'd0);

        runOp("add_wrap", 8'hFF, 8'h01, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
        runOp("add_ovf", 8'h7F, 8'h01, 8'h20, 8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("add_ovf_flag", 32'(overflow), 32'(OVF_ON));
        runOp("sub_borrow", 8'h05, 8'h07, 8'h22, 8'hFE, 1'b1, 1'b0, 1'b0);
        runOp("sra", 8'h80, 8'h03, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0);

        // Async reset after A and B loaded: must clear without waiting for a clock edge
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_out", 32'(out), 32'd0);
        checkOutput("midrst_zero", 32'(zero), 32'd1);
        #1 reset = 1'b0;
        runOp("after_rst", 8'h03, 8'h04, 8'h20, 8'h07, 1'b0, 1'b0, 1'b0);

        // Reset while executing: no result, no done
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h20, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        checkOutput("execrst_state", 32'(state), 32'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("execrst_done", 32'(done), 32'd0);
        checkOutput("execrst_out", 32'(out), 32'd0);

        runOp("srl_big", 8'h80, 8'h09, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0);

        // clear together with load in S_OP: back to S_A, opcode dropped
        applyStimulus(8'h0A, 1'b1, 1'b0);
        applyStimulus(8'h0B, 1'b1, 1'b0);
        applyStimulus(8'h20, 1'b1, 1'b1);
        checkOutput("clrld_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("clrld_done", 32'(done), 32'd0);

        // load during execution is ignored
        applyStimulus(8'h0A, 1'b1, 1'b0);
        applyStimulus(8'h0B, 1'b1, 1'b0);
        applyStimulus(8'h20, 1'b1, 1'b0);
        data_in = 8'h55;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        checkOutput("execld_out", 32'(out), 32'h15);
        checkOutput("execld_state", 32'(state), 32'd0);
        checkOutput("execld_done", 32'(done), 32'd1);
        runOp("after_execld", 8'h02, 8'h03, 8'h26, 8'h01, 1'b0, 1'b0, 1'b0);

        // clear in S_B restarts the sequence
        applyStimulus(8'h40, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("clrb_state", 32'(state), 32'd0);
        runOp("after_clrb", 8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b0, 1'b0, 1'b0);

        runOp("unsup", 8'h12, 8'h34, 8'h3F, 8'h00, 1'b0, 1'b1, 1'b1);
        runOp("nor", 8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
